// File: rtl/fb_pkg.sv
// Shared constants, register map and enumerations for the frame-buffer port arbiter.
package fb_pkg;

    localparam int unsigned FB_W      = 640;
    localparam int unsigned FB_H      = 480;
    localparam int unsigned FB_PIXELS = FB_W * FB_H;
    localparam int unsigned PIX_W     = 5;
    localparam int unsigned ADDR_W    = 19;

    localparam logic [1:0] REG_CTRL        = 2'd0;
    localparam logic [1:0] REG_STATUS      = 2'd1;
    localparam logic [1:0] REG_CLEAR_COLOR = 2'd2;

    typedef enum logic [1:0] {GNT_NONE, GNT_SCAN, GNT_CLEAR, GNT_CPU} fb_gnt_t;
    typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_t;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Avalon-MM slave bundle between the CPU fabric and the frame-buffer arbiter.
interface fb_port_arbiter_if;

    logic        AVL_READ;
    logic        AVL_WRITE;
    logic        AVL_CS;
    logic [20:0] AVL_ADDR;
    logic [7:0]  AVL_WRITEDATA;
    logic [7:0]  AVL_READDATA;
    logic        AVL_WAITREQUEST;

    modport master (
        output AVL_READ, AVL_WRITE, AVL_CS, AVL_ADDR, AVL_WRITEDATA,
        input  AVL_READDATA, AVL_WAITREQUEST
    );

    modport slave (
        input  AVL_READ, AVL_WRITE, AVL_CS, AVL_ADDR, AVL_WRITEDATA,
        output AVL_READDATA, AVL_WAITREQUEST
    );

endinterface

// File: rtl/fb_clear_engine.sv
// Back-buffer fill engine: walks every pixel index once, advancing only on its own grant.
module fb_clear_engine
    import fb_pkg::*;
#(
    parameter int unsigned N_PIX  = FB_PIXELS,
    parameter int unsigned CNT_W  = 19,
    parameter int unsigned DATA_W = 5
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic [DATA_W-1:0] color,
    input  fb_gnt_t           gnt,
    output logic              req,
    output logic              busy,
    output logic [CNT_W-1:0]  ptr,
    output logic [DATA_W-1:0] wdata
);

    clr_state_t state;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= CLR_IDLE;
            ptr   <= '0;
        end else begin
            case (state)
                CLR_IDLE: begin
                    if (start) begin
                        state <= CLR_RUN;
                        ptr   <= '0;
                    end
                end
                CLR_RUN: begin
                    if (gnt == GNT_CLEAR) begin
                        if (ptr == CNT_W'(N_PIX - 1)) state <= CLR_IDLE;
                        else                          ptr   <= ptr + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Colour is not latched at start so a mid-clear change applies to later pixels.
    assign busy  = (state == CLR_RUN);
    assign req   = busy;
    assign wdata = color;

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: scanout reads, CPU pixel writes and clear fills,
// with CPU-requested front/back buffer swap committed at frame start.
module fb_port_arbiter #(
    parameter int unsigned FB_W   = fb_pkg::FB_W,
    parameter int unsigned FB_H   = fb_pkg::FB_H,
    parameter int unsigned PIX_W  = fb_pkg::PIX_W,
    parameter int unsigned ADDR_W = fb_pkg::ADDR_W
) (
    input  logic              CLK,
    input  logic              RESET,
    fb_port_arbiter_if.slave  avl,
    input  logic              pix_en,
    input  logic              frame_start,
    input  logic [9:0]        fb_drawX,
    input  logic [9:0]        fb_drawY,
    output logic [PIX_W-1:0]  fb_color,
    output logic [ADDR_W:0]   mem_addr,
    output logic              mem_we,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata
);
    import fb_pkg::*;

    localparam int unsigned N_PIX = FB_W * FB_H;

    logic              front, swap_pending;
    logic              clear_busy, clear_req;
    logic [PIX_W-1:0]  clear_color, clear_wdata;
    logic [ADDR_W-1:0] clear_ptr, scan_idx, cpu_idx;
    logic              cpu_req, reg_wr, reg_rd, ctrl_wr, scan_req;
    logic              scan_d, scan_hit_d;
    fb_gnt_t           gnt, last_gnt;
    logic              unused_bits;

    assign cpu_req  = avl.AVL_CS & avl.AVL_WRITE & ~avl.AVL_ADDR[20];
    assign reg_wr   = avl.AVL_CS & avl.AVL_WRITE &  avl.AVL_ADDR[20];
    assign reg_rd   = avl.AVL_CS & avl.AVL_READ  &  avl.AVL_ADDR[20];
    assign ctrl_wr  = reg_wr && (avl.AVL_ADDR[1:0] == REG_CTRL);
    assign scan_req = pix_en && (fb_drawX < 10'(FB_W)) && (fb_drawY < 10'(FB_H));
    assign scan_idx = ADDR_W'(fb_drawX) + (ADDR_W'(fb_drawY) << 9) + (ADDR_W'(fb_drawY) << 7);
    assign cpu_idx  = avl.AVL_ADDR[ADDR_W-1:0];
    assign unused_bits = ^{avl.AVL_ADDR[19:ADDR_W], avl.AVL_WRITEDATA[7:PIX_W]};

    fb_clear_engine #(
        .N_PIX  (N_PIX),
        .CNT_W  (ADDR_W),
        .DATA_W (PIX_W)
    ) u_clear (
        .CLK   (CLK),
        .RESET (RESET),
        .start (ctrl_wr & avl.AVL_WRITEDATA[1]),
        .color (clear_color),
        .gnt   (gnt),
        .req   (clear_req),
        .busy  (clear_busy),
        .ptr   (clear_ptr),
        .wdata (clear_wdata)
    );

    // Scan always wins; clear and CPU take turns when both are waiting.
    always_comb begin
        gnt = GNT_NONE;
        if (RESET)                  gnt = GNT_NONE;
        else if (scan_req)          gnt = GNT_SCAN;
        else if (clear_req && cpu_req)
            gnt = (last_gnt == GNT_CLEAR) ? GNT_CPU : GNT_CLEAR;
        else if (clear_req)         gnt = GNT_CLEAR;
        else if (cpu_req)           gnt = GNT_CPU;
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (gnt)
            GNT_SCAN:  mem_addr = {front, scan_idx};
            GNT_CLEAR: begin
                mem_addr  = {~front, clear_ptr};
                mem_we    = 1'b1;
                mem_wdata = clear_wdata;
            end
            GNT_CPU: begin
                mem_addr  = {~front, cpu_idx};
                mem_we    = (cpu_idx < ADDR_W'(N_PIX));
                mem_wdata = avl.AVL_WRITEDATA[PIX_W-1:0];
            end
            default: ;
        endcase
    end

    assign avl.AVL_WAITREQUEST = ~RESET & cpu_req & (gnt != GNT_CPU);

    always_comb begin
        avl.AVL_READDATA = '0;
        if (reg_rd && !RESET) begin
            case (avl.AVL_ADDR[1:0])
                REG_STATUS:      avl.AVL_READDATA = {5'b0, clear_busy, swap_pending, front};
                REG_CLEAR_COLOR: avl.AVL_READDATA = 8'(clear_color);
                default:         avl.AVL_READDATA = '0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            front        <= 1'b0;
            swap_pending <= 1'b0;
            clear_color  <= '0;
            last_gnt     <= GNT_CPU;
            fb_color     <= '0;
            scan_d       <= 1'b0;
            scan_hit_d   <= 1'b0;
        end else begin
            if (gnt == GNT_CLEAR || gnt == GNT_CPU) last_gnt <= gnt;
            if (reg_wr && avl.AVL_ADDR[1:0] == REG_CLEAR_COLOR)
                clear_color <= avl.AVL_WRITEDATA[PIX_W-1:0];
            // A fresh swap request masks a coincident frame_start.
            if (ctrl_wr && avl.AVL_WRITEDATA[0]) begin
                swap_pending <= 1'b1;
            end else if (frame_start && swap_pending && !clear_busy) begin
                front        <= ~front;
                swap_pending <= 1'b0;
            end
            scan_d     <= pix_en;
            scan_hit_d <= scan_req;
            if (scan_d) fb_color <= scan_hit_d ? mem_rdata : '0;
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Scoreboard bench for fb_port_arbiter with a reduced frame height to keep clears short.
module tb_fb_port_arbiter;
    import fb_pkg::*;

    localparam int TB_H = 16;
    localparam int N    = 640 * TB_H;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    fb_port_arbiter_if avl ();
    logic        pix_en = 1'b0, frame_start = 1'b0;
    logic [9:0]  drawX = '0, drawY = '0;
    logic [4:0]  fb_color, mem_wdata, mem_rdata;
    logic [19:0] mem_addr;
    logic        mem_we;

    fb_port_arbiter #(.FB_H(TB_H)) dut (
        .CLK(CLK), .RESET(RESET), .avl(avl),
        .pix_en(pix_en), .frame_start(frame_start),
        .fb_drawX(drawX), .fb_drawY(drawY), .fb_color(fb_color),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    int n_cmp = 0, n_bad = 0;
    function automatic void check(input string name, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endfunction

    // Reference state
    logic [4:0] refm [0:1][0:N-1];
    logic       front_m = 1'b0;
    logic [4:0] color_m = '0;

    typedef struct packed { logic oor; logic [19:0] addr; logic [4:0] data; } wr_t;
    wr_t        cpu_q[$];
    logic       scan_hit_q[$];
    logic [19:0] scan_addr_q[$];
    logic [4:0] scan_col_q[$];

    // Frame-buffer RAM, 1-cycle read latency
    logic [4:0] ram [0:(1<<20)-1];
    logic       preload = 1'b0;
    always @(posedge CLK) begin
        if (preload) for (int i = 0; i < N; i++) ram[i] <= refm[0][i];
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Monitor: pops expectations whenever the DUT commits or presents a result
    int   clr_cnt = 0;
    logic d1 = 1'b0, d2 = 1'b0;
    always @(negedge CLK) begin : monitor
        wr_t  e;
        logic commit, hit;
        if (RESET) begin
            clr_cnt <= 0;
            d1 <= 1'b0;
            d2 <= 1'b0;
        end else begin
            commit = avl.AVL_CS && avl.AVL_WRITE && !avl.AVL_ADDR[20] && !avl.AVL_WAITREQUEST;
            if (commit) begin
                if (cpu_q.size() == 0) check("cpu_unexpected_commit", 1, 0);
                else begin
                    e = cpu_q.pop_front();
                    if (e.oor) check("cpu_oor_we", mem_we, 0);
                    else begin
                        check("cpu_we", mem_we, 1);
                        check("cpu_addr", mem_addr, e.addr);
                        check("cpu_data", mem_wdata, e.data);
                    end
                end
            end else if (mem_we) begin
                check("clear_addr", mem_addr, {~front_m, 19'(clr_cnt % N)});
                check("clear_data", mem_wdata, color_m);
                clr_cnt <= clr_cnt + 1;
            end
            if (d2) begin
                if (scan_col_q.size() == 0) check("scan_color_underflow", 1, 0);
                else check("scan_color", fb_color, scan_col_q.pop_front());
            end
            if (pix_en && scan_hit_q.size() != 0) begin
                hit = scan_hit_q.pop_front();
                if (hit) begin
                    check("scan_addr", mem_addr, scan_addr_q.pop_front());
                    check("scan_we", mem_we, 0);
                end else void'(scan_addr_q.pop_front());
            end
            d2 <= d1;
            d1 <= pix_en;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic reg_write(input logic [1:0] off, input logic [7:0] d);
        avl.AVL_CS = 1'b1; avl.AVL_WRITE = 1'b1;
        avl.AVL_ADDR = {1'b1, 18'b0, off}; avl.AVL_WRITEDATA = d;
        @(negedge CLK) check("reg_wr_wait", avl.AVL_WAITREQUEST, 0);
        tick();
        avl.AVL_CS = 1'b0; avl.AVL_WRITE = 1'b0;
        if (off == REG_CLEAR_COLOR) color_m = d[4:0];
    endtask

    task automatic reg_read(input logic [1:0] off, output logic [7:0] d);
        avl.AVL_CS = 1'b1; avl.AVL_READ = 1'b1; avl.AVL_ADDR = {1'b1, 18'b0, off};
        @(negedge CLK) d = avl.AVL_READDATA;
        tick();
        avl.AVL_CS = 1'b0; avl.AVL_READ = 1'b0;
    endtask

    task automatic check_status(input string name, input logic [7:0] exp);
        logic [7:0] s;
        reg_read(REG_STATUS, s);
        check(name, s, exp);
    endtask

    task automatic cpu_write(input logic [18:0] idx, input logic [4:0] d, output int waits);
        wr_t e;
        e.oor = (int'(idx) >= N); e.addr = {~front_m, idx}; e.data = d;
        cpu_q.push_back(e);
        if (!e.oor) refm[~front_m][idx] = d;
        avl.AVL_CS = 1'b1; avl.AVL_WRITE = 1'b1;
        avl.AVL_ADDR = {2'b00, idx}; avl.AVL_WRITEDATA = {3'b0, d};
        waits = 0;
        forever begin
            @(negedge CLK);
            if (!avl.AVL_WAITREQUEST) break;
            waits++;
            if (waits > 100) begin check("cpu_write_timeout", 1, 0); break; end
        end
        tick();
        avl.AVL_CS = 1'b0; avl.AVL_WRITE = 1'b0;
    endtask

    task automatic scan(input int x, input int y);
        logic hit;
        int   idx;
        hit = (x < 640) && (y < TB_H);
        idx = x + 640 * y;
        scan_hit_q.push_back(hit);
        scan_addr_q.push_back({front_m, 19'(idx)});
        scan_col_q.push_back(hit ? refm[front_m][idx] : 5'd0);
        pix_en = 1'b1; drawX = 10'(x); drawY = 10'(y);
        tick();
        pix_en = 1'b0;
        tick();
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic start_clear();
        reg_write(REG_CTRL, 8'h02);
        for (int i = 0; i < N; i++) refm[~front_m][i] = color_m;
    endtask

    task automatic wait_clear_done(input string name);
        logic [7:0] s;
        s = 8'h04;
        for (int k = 0; k < 3 * N && s[2]; k++) reg_read(REG_STATUS, s);
        check(name, s[2], 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, bad;
        int t3_idx[$];
        logic t3_done;
        logic [7:0] s;
        logic [18:0] idx;

        avl.AVL_CS = 1'b0; avl.AVL_READ = 1'b0; avl.AVL_WRITE = 1'b0;
        avl.AVL_ADDR = '0; avl.AVL_WRITEDATA = '0;
        for (int i = 0; i < N; i++) begin
            refm[0][i] = 5'($urandom);
            refm[1][i] = 5'd0;
        end
        refm[0][1283] = 5'd7;
        tick();
        preload = 1'b1;
        tick();
        preload = 1'b0;

        // Reset with a pixel write pending must stay quiet
        avl.AVL_CS = 1'b1; avl.AVL_WRITE = 1'b1; avl.AVL_ADDR = 21'd9;
        @(negedge CLK);
        check("rst_mem_we", mem_we, 0);
        check("rst_waitreq", avl.AVL_WAITREQUEST, 0);
        check("rst_fb_color", fb_color, 0);
        tick();
        avl.AVL_CS = 1'b0; avl.AVL_WRITE = 1'b0;
        RESET = 1'b0;
        tick();

        // 1: status after reset, simple pixel write into back buffer 1
        check_status("t1_status", 8'h00);
        cpu_write(19'd5, 5'h13, w);
        check("t1_waits", w, 0);

        // 2: scanout latency and out-of-range columns/rows
        scan(3, 2);
        fork
            scan(640, 2);
            begin @(negedge CLK); check("t2_oor_no_we", mem_we, 0); end
        join
        scan(639, TB_H - 1);
        scan(0, TB_H);
        scan(5, 9);

        // 3: write held off by a scan slot, then random writes under scanout
        fork
            scan(10, 3);
            cpu_write(19'd100, 5'h0a, w);
        join
        check("t3_held_waits", w, 1);
        t3_idx.push_back(100);
        cpu_write(19'(N - 1), 5'h1e, w);
        t3_idx.push_back(N - 1);
        cpu_write(19'(N), 5'h1f, w);
        t3_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 100; k++) begin
                    idx = ($urandom_range(7) == 0) ? 19'($urandom_range(524287, N))
                                                   : 19'($urandom_range(N - 1));
                    cpu_write(idx, 5'($urandom), w);
                    if (int'(idx) < N) t3_idx.push_back(int'(idx));
                end
                t3_done = 1'b1;
            end
            while (!t3_done) scan($urandom_range(700), $urandom_range(TB_H + 3));
        join
        repeat (3) tick();
        bad = 0;
        foreach (t3_idx[k]) if (ram[{1'b1, 19'(t3_idx[k])}] !== refm[1][t3_idx[k]]) bad++;
        check("t3_ram_lost_writes", bad, 0);

        // 4: clear interleaved with back-to-back CPU writes
        reg_write(REG_CLEAR_COLOR, 8'h09);
        reg_read(REG_CLEAR_COLOR, s);
        check("t4_color_readback", s, 8'h09);
        start_clear();
        for (int j = 0; j < 200; j++) begin
            cpu_write(19'(j), 5'($urandom), w);
            check("t4_alternate_waits", w, 1);
        end
        wait_clear_done("t4_busy_fell");
        check("t4_clear_grants", clr_cnt, N);
        for (int j = 0; j < 20; j++) begin
            cpu_write(19'($urandom_range(N - 1)), 5'($urandom), w);
            check("t4_idle_waits", w, 0);
        end
        tick();
        bad = 0;
        for (int i = 0; i < N; i++) if (ram[{1'b1, 19'(i)}] !== refm[1][i]) bad++;
        check("t4_backbuf", bad, 0);

        // 5: swap at frame start, and swap request coincident with frame start
        check_status("t5_idle", 8'h00);
        reg_write(REG_CTRL, 8'h01);
        check_status("t5_pending", 8'h02);
        frame();
        front_m = 1'b1;
        check_status("t5_swapped", 8'h01);
        scan(7, 1);
        fork
            reg_write(REG_CTRL, 8'h01);
            frame();
        join
        check_status("t5_coincident", 8'h03);
        frame();
        front_m = 1'b0;
        check_status("t5_second_swap", 8'h00);

        // 6: swap blocked by clear, then reset mid-clear
        reg_write(REG_CTRL, 8'h01);
        start_clear();
        frame();
        check_status("t6_blocked", 8'h06);
        wait_clear_done("t6_busy_fell");
        check("t6_clear_grants", clr_cnt, 2 * N);
        check_status("t6_pending_after", 8'h02);
        frame();
        front_m = 1'b1;
        check_status("t6_swapped", 8'h01);
        reg_write(REG_CTRL, 8'h03);
        repeat (40) tick();
        RESET = 1'b1;
        front_m = 1'b0;
        color_m = 5'd0;
        repeat (2) tick();
        RESET = 1'b0;
        check_status("t6_reset_status", 8'h00);
        reg_read(REG_CLEAR_COLOR, s);
        check("t6_reset_color", s, 8'h00);
        reg_write(REG_CTRL, 8'h02);
        repeat (5) tick();
        check("t6_restart_ptr", clr_cnt, 5);
        RESET = 1'b1;
        repeat (3) tick();

        check("cpu_queue_drained", cpu_q.size(), 0);
        check("scan_queue_drained", scan_col_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
